fadd_s1_lanes: RTL and testbench

Multi-lane, pipelined front stage for the tensor-core floating-point adder. Each cycle it accepts NUM_LANES operand pairs plus a tag, then per lane: classifies operands, applies the add/sub mode and resolves special cases. It also orders operands by exponent and makes the far/near path decision. Results are registered into a 2-entry output buffer with valid/ready handshakes, so the block drops in ahead of the per-lane far/near path datapaths and tolerates back-pressure without bubbles.

---
 rtl/fadd_s1_lanes.sv | 167 ++++++++++++++++
 tb/tb_fadd_s1_lanes.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_s1_lanes.sv
// fadd_s1_lanes: multi-lane FP adder front stage. Per lane it classifies
// operands, orders them by exponent and picks the far/near path.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid_i      input beat valid
//   in_ready_o      block can accept a beat
//   in_a_i          operand A per lane
//   in_b_i          operand B per lane
//   in_sub_i        subtract mode
//   in_rm_i         rounding mode, passed through
//   in_mask_i       lane enables
//   in_tag_i        beat tag, passed through
//   out_valid_o     output beat valid
//   out_ready_i     consumer accepts beat
//   out_rm_o        rounding mode of the output beat
//   out_tag_o       tag of the output beat
//   out_mask_o      lane mask of the output beat
//   out_lane_o      per-lane records
//   out_busy_o      output buffer non-empty
module fadd_s1_lanes #(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24,
    parameter int NUM_LANES = 4,
    parameter int TAG_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  logic [NUM_LANES*(EXPWIDTH+PRECISION)-1:0] in_a_i,
    input  logic [NUM_LANES*(EXPWIDTH+PRECISION)-1:0] in_b_i,
    input  logic in_sub_i,
    input  logic [2:0] in_rm_i,
    input  logic [NUM_LANES-1:0] in_mask_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output logic [2:0] out_rm_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [NUM_LANES-1:0] out_mask_o,
    output logic [NUM_LANES*(2*PRECISION+2*EXPWIDTH+8)-1:0] out_lane_o,
    output logic out_busy_o
);

    localparam int E  = EXPWIDTH;
    localparam int P  = PRECISION;
    localparam int W  = E + P;
    localparam int L  = 2*P + 2*E + 8;
    localparam int BW = NUM_LANES * L;

    function automatic logic [L-1:0] proc_lane(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         sub
    );
        logic         a_s, b_s;
        logic [E-1:0] a_e, b_e, a_ee, b_ee;
        logic [P-2:0] a_f, b_f;
        logic [P-1:0] a_sig, b_sig, big_sig, small_sig;
        logic         a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
        logic         eff_sub, small_add, swap, sel_far;
        logic         big_sign;
        logic [E-1:0] big_exp, expdiff;
        logic         spc_valid, spc_iv, spc_nan, spc_inf_sign;

        a_s = a[W-1];
        b_s = b[W-1] ^ sub;
        a_e = a[W-2 -: E];
        b_e = b[W-2 -: E];
        a_f = a[P-2:0];
        b_f = b[P-2:0];

        // Subnormals share exponent 1 with the smallest normals.
        a_ee  = (a_e == '0) ? E'(1) : a_e;
        b_ee  = (b_e == '0) ? E'(1) : b_e;
        a_sig = {(a_e != '0), a_f};
        b_sig = {(b_e != '0), b_f};

        a_inf  = (&a_e) && (a_f == '0);
        b_inf  = (&b_e) && (b_f == '0);
        a_nan  = (&a_e) && (a_f != '0);
        b_nan  = (&b_e) && (b_f != '0);
        a_snan = a_nan && !a_f[P-2];
        b_snan = b_nan && !b_f[P-2];

        eff_sub   = a_s ^ b_s;
        small_add = (a_e == '0) && (b_e == '0);
        swap      = b_ee > a_ee;

        big_sig   = swap ? b_sig : a_sig;
        small_sig = swap ? a_sig : b_sig;
        big_exp   = swap ? b_ee : a_ee;
        big_sign  = swap ? b_s : a_s;
        expdiff   = swap ? (b_ee - a_ee) : (a_ee - b_ee);
        sel_far   = !eff_sub || (expdiff > E'(1));

        spc_valid    = a_nan || b_nan || a_inf || b_inf;
        spc_iv       = a_snan || b_snan || (a_inf && b_inf && eff_sub);
        spc_nan      = a_nan || b_nan || (a_inf && b_inf && eff_sub);
        spc_inf_sign = a_inf ? a_s : b_s;

        return {spc_inf_sign, spc_nan, spc_iv, spc_valid,
                small_add, eff_sub, sel_far, big_sign,
                big_exp, expdiff, big_sig, small_sig};
    endfunction

    logic [BW-1:0] lane_d;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_d[k*L +: L] = in_mask_i[k]
            ? proc_lane(in_a_i[k*W +: W], in_b_i[k*W +: W], in_sub_i)
            : '0;
    end

    logic [BW-1:0]        lane_mem [2];
    logic [2:0]           rm_mem   [2];
    logic [TAG_W-1:0]     tag_mem  [2];
    logic [NUM_LANES-1:0] mask_mem [2];
    logic                 wptr, rptr;
    logic [1:0]           cnt;
    logic                 push, pop;

    // Ready comes from the registered count, so a pop while full only
    // reopens the input on the following cycle.
    assign in_ready_o  = (cnt != 2'd2);
    assign out_valid_o = (cnt != 2'd0);
    assign out_busy_o  = (cnt != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                lane_mem[i] <= '0;
                rm_mem[i]   <= '0;
                tag_mem[i]  <= '0;
                mask_mem[i] <= '0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) begin
                lane_mem[wptr] <= lane_d;
                rm_mem[wptr]   <= in_rm_i;
                tag_mem[wptr]  <= in_tag_i;
                mask_mem[wptr] <= in_mask_i;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign out_lane_o = lane_mem[rptr];
    assign out_rm_o   = rm_mem[rptr];
    assign out_tag_o  = tag_mem[rptr];
    assign out_mask_o = mask_mem[rptr];

endmodule

// File: tb/tb_fadd_s1_lanes.sv
// tb_fadd_s1_lanes: table vectors, directed handshake sequences and a
// randomized run against a queue-based reference model.
module tb_fadd_s1_lanes;

    localparam int NL = 4;
    localparam int L  = 72;
    localparam int BW = NL * L;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [NL*32-1:0] in_a_i, in_b_i;
    logic            in_sub_i;
    logic [2:0]      in_rm_i;
    logic [NL-1:0]   in_mask_i;
    logic [7:0]      in_tag_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [2:0]      out_rm_o;
    logic [7:0]      out_tag_o;
    logic [NL-1:0]   out_mask_o;
    logic [BW-1:0]   out_lane_o;
    logic            out_busy_o;

    fadd_s1_lanes dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_sub_i(in_sub_i),
        .in_rm_i(in_rm_i), .in_mask_i(in_mask_i), .in_tag_i(in_tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_rm_o(out_rm_o), .out_tag_o(out_tag_o),
        .out_mask_o(out_mask_o), .out_lane_o(out_lane_o),
        .out_busy_o(out_busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected record from hand-derived fields.
    // flags = {inf_sign, nan, iv, spc_valid, small_add, eff_sub, far, big_sign}
    function automatic logic [L-1:0] mk(
        input logic [23:0] ss, input logic [23:0] bs,
        input logic [7:0] ed, input logic [7:0] be, input logic [7:0] flags);
        return {flags, be, ed, bs, ss};
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic logic [L-1:0] ref_lane(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic sub);
        int ea_f, eb_f, fa, fb, ea, eb, siga, sigb, d;
        int bsig, ssig, bexp;
        bit sa, sb, ainf, binf, anan, bnan, asn, bsn;
        bit esub, far, bsign, sv, iv, nan, infs, sadd;
        ea_f = int'(a[30:23]);
        eb_f = int'(b[30:23]);
        fa   = int'(a[22:0]);
        fb   = int'(b[22:0]);
        sa   = a[31];
        sb   = b[31] ^ sub;
        ea   = (ea_f == 0) ? 1 : ea_f;
        eb   = (eb_f == 0) ? 1 : eb_f;
        siga = ((ea_f != 0) ? (1 << 23) : 0) + fa;
        sigb = ((eb_f != 0) ? (1 << 23) : 0) + fb;
        ainf = (ea_f == 255) && (fa == 0);
        binf = (eb_f == 255) && (fb == 0);
        anan = (ea_f == 255) && (fa != 0);
        bnan = (eb_f == 255) && (fb != 0);
        asn  = anan && (fa < (1 << 22));
        bsn  = bnan && (fb < (1 << 22));
        esub = sa != sb;
        sadd = (ea_f == 0) && (eb_f == 0);
        if (eb > ea) begin
            bsig = sigb; ssig = siga; bexp = eb; bsign = sb;
        end else begin
            bsig = siga; ssig = sigb; bexp = ea; bsign = sa;
        end
        d    = (ea > eb) ? ea - eb : eb - ea;
        far  = !esub || (d > 1);
        sv   = anan || bnan || ainf || binf;
        iv   = asn || bsn || (ainf && binf && esub);
        nan  = anan || bnan || (ainf && binf && esub);
        infs = ainf ? sa : sb;
        return {infs, nan, iv, sv, sadd, esub, far, bsign,
                8'(bexp), 8'(d), 24'(bsig), 24'(ssig)};
    endfunction

    typedef struct {
        logic [BW-1:0] lane;
        logic [2:0]    rm;
        logic [7:0]    tag;
        logic [NL-1:0] mask;
    } beat_t;

    function automatic beat_t ref_beat();
        beat_t bt;
        for (int k = 0; k < NL; k++) begin
            bt.lane[k*L +: L] = in_mask_i[k]
                ? ref_lane(in_a_i[k*32 +: 32], in_b_i[k*32 +: 32], in_sub_i)
                : '0;
        end
        bt.rm   = in_rm_i;
        bt.tag  = in_tag_i;
        bt.mask = in_mask_i;
        return bt;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 4))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'(126 + $urandom_range(0, 3));
            default: e = 8'($urandom);
        endcase
        f = 23'($urandom);
        if ($urandom_range(0, 3) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic          sub;
        logic [NL-1:0] mask;
        logic [L-1:0]  exp;
    } vec_t;

    vec_t  vecs[9];
    beat_t q[$];
    beat_t bt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'hF,
                    mk(24'h800000, 24'h800000, 8'h01, 8'h80, 8'b0000_0010)};
        vecs[1] = '{32'h40000000, 32'h3F800000, 1'b1, 4'hF,
                    mk(24'h800000, 24'h800000, 8'h01, 8'h80, 8'b1000_0100)};
        vecs[2] = '{32'h41800000, 32'h3F800000, 1'b1, 4'hF,
                    mk(24'h800000, 24'h800000, 8'h04, 8'h83, 8'b1000_0110)};
        vecs[3] = '{32'h7F800000, 32'h7F800000, 1'b1, 4'hF,
                    mk(24'h800000, 24'h800000, 8'h00, 8'hFF, 8'b0111_0100)};
        vecs[4] = '{32'h7F800001, 32'h3F800000, 1'b0, 4'hF,
                    mk(24'h800000, 24'h800001, 8'h80, 8'hFF, 8'b0111_0010)};
        vecs[5] = '{32'h00000001, 32'h00000002, 1'b0, 4'b0101,
                    mk(24'h000002, 24'h000001, 8'h00, 8'h01, 8'b0000_1010)};
        vecs[6] = '{32'h3F800000, 32'hFFC00000, 1'b0, 4'hF,
                    mk(24'h800000, 24'hC00000, 8'h80, 8'hFF, 8'b1101_0111)};
        vecs[7] = '{32'hFF800000, 32'h7F800000, 1'b0, 4'hF,
                    mk(24'h800000, 24'h800000, 8'h00, 8'hFF, 8'b1111_0101)};
        vecs[8] = '{32'h3F800000, 32'hFF800000, 1'b1, 4'hF,
                    mk(24'h800000, 24'h800000, 8'h80, 8'hFF, 8'b0001_0010)};

        rst = 1'b1;
        in_valid_i = 1'b0;
        in_a_i = '0;
        in_b_i = '0;
        in_sub_i = 1'b0;
        in_rm_i = '0;
        in_mask_i = '0;
        in_tag_i = '0;
        out_ready_i = 1'b0;
        tick();
        tick();

        chk("rst_valid", BW'(out_valid_o), BW'(1'b0));
        chk("rst_ready", BW'(in_ready_o), BW'(1'b1));
        chk("rst_busy", BW'(out_busy_o), BW'(1'b0));
        chk("rst_lane", out_lane_o, '0);
        chk("rst_meta", BW'({out_rm_o, out_tag_o, out_mask_o}), '0);

        // Table vectors, one beat each, all lanes carry the same pair.
        rst = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid_i = 1'b1;
            in_a_i     = {NL{vecs[i].a}};
            in_b_i     = {NL{vecs[i].b}};
            in_sub_i   = vecs[i].sub;
            in_mask_i  = vecs[i].mask;
            in_rm_i    = 3'(i);
            in_tag_i   = 8'(8'h40 + i);
            tick();
            in_valid_i = 1'b0;
            chk($sformatf("vec%0d_valid", i), BW'(out_valid_o), BW'(1'b1));
            chk($sformatf("vec%0d_meta", i),
                BW'({out_rm_o, out_tag_o, out_mask_o}),
                BW'({3'(i), 8'(8'h40 + i), vecs[i].mask}));
            for (int k = 0; k < NL; k++) begin
                chk($sformatf("vec%0d_lane%0d", i, k),
                    BW'(out_lane_o[k*L +: L]),
                    BW'(vecs[i].mask[k] ? vecs[i].exp : '0));
            end
            tick();
            chk($sformatf("vec%0d_drain", i), BW'(out_valid_o), BW'(1'b0));
        end

        // Back-pressure: three beats offered, two fit.
        out_ready_i = 1'b0;
        in_mask_i = 4'hF;
        in_valid_i = 1'b1;
        in_tag_i = 8'd1;
        tick();
        chk("bp_ready1", BW'(in_ready_o), BW'(1'b1));
        in_tag_i = 8'd2;
        tick();
        chk("bp_full_ready", BW'(in_ready_o), BW'(1'b0));
        chk("bp_head_tag", BW'(out_tag_o), BW'(8'd1));
        in_tag_i = 8'd3;
        tick();
        chk("bp_hold_ready", BW'(in_ready_o), BW'(1'b0));
        chk("bp_hold_tag", BW'(out_tag_o), BW'(8'd1));
        out_ready_i = 1'b1;
        tick();
        chk("bp_pop1_tag", BW'(out_tag_o), BW'(8'd2));
        chk("bp_pop1_ready", BW'(in_ready_o), BW'(1'b1));
        tick();
        in_valid_i = 1'b0;
        chk("bp_tag3_valid", BW'(out_valid_o), BW'(1'b1));
        chk("bp_tag3", BW'(out_tag_o), BW'(8'd3));
        tick();
        chk("bp_empty", BW'(out_valid_o), BW'(1'b0));
        tick();
        chk("bp_empty_pop", BW'(out_valid_o), BW'(1'b0));

        // Reset while full discards buffered beats.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        in_tag_i = 8'hAA;
        tick();
        in_tag_i = 8'hBB;
        tick();
        in_valid_i = 1'b0;
        chk("rf_full", BW'(in_ready_o), BW'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rf_valid", BW'(out_valid_o), BW'(1'b0));
        chk("rf_ready", BW'(in_ready_o), BW'(1'b1));
        chk("rf_busy", BW'(out_busy_o), BW'(1'b0));
        chk("rf_lane", out_lane_o, '0);
        chk("rf_tag", BW'(out_tag_o), '0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rf_no_old", BW'(out_valid_o), BW'(1'b0));
        end

        // Randomized run against the queue model.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", BW'(out_valid_o), BW'(q.size() != 0));
            chk("rnd_ready", BW'(in_ready_o), BW'(q.size() < 2));
            chk("rnd_busy", BW'(out_busy_o), BW'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_lane", out_lane_o, q[0].lane);
                chk("rnd_meta", BW'({out_rm_o, out_tag_o, out_mask_o}),
                    BW'({q[0].rm, q[0].tag, q[0].mask}));
            end
            rst         = ($urandom_range(0, 99) < 2);
            in_valid_i  = ($urandom_range(0, 99) < 70);
            out_ready_i = ($urandom_range(0, 99) < 65);
            for (int k = 0; k < NL; k++) begin
                in_a_i[k*32 +: 32] = rnd_op();
                in_b_i[k*32 +: 32] = rnd_op();
            end
            in_sub_i  = 1'($urandom);
            in_rm_i   = 3'($urandom);
            in_mask_i = 4'($urandom);
            in_tag_i  = 8'(c);
            if (rst) begin
                q.delete();
            end else begin
                bit can_push;
                can_push = q.size() < 2;
                if (q.size() != 0 && out_ready_i) void'(q.pop_front());
                if (in_valid_i && can_push) begin
                    bt = ref_beat();
                    q.push_back(bt);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
